// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 (7,5 octal) hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int INIT_PEN   = 4;

    // Trellis state {a,b}: a = previous input bit, b = the bit before it.
    typedef logic [1:0] state_t;

    // Encoder output {o1,o0} leaving state s on input u (generators 7 and 5 octal).
    function automatic logic [1:0] exp_sym(state_t s, logic u);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction

    // Hamming distance between two 2-bit symbols, 0..2.
    function automatic logic [1:0] hamming2(logic [1:0] x, logic [1:0] y);
        logic [1:0] d;
        d = x ^ y;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state ns={u,a}; predecessors are {a,0} and {a,1}.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int     METRIC_W = 4,
    parameter state_t NS       = 2'b00
) (
    input  logic [METRIC_W-1:0] pm_p0,
    input  logic [METRIC_W-1:0] pm_p1,
    input  logic [1:0]          sym,
    output logic [METRIC_W-1:0] new_pm,
    output logic                dec
);

    localparam state_t P0 = {NS[0], 1'b0};
    localparam state_t P1 = {NS[0], 1'b1};

    logic [1:0]          bm0;
    logic [1:0]          bm1;
    logic [METRIC_W-1:0] cand0;
    logic [METRIC_W-1:0] cand1;

    // Two candidates, keep the smaller; a tie keeps the even predecessor.
    always_comb begin
        bm0    = hamming2(sym, exp_sym(P0, NS[1]));
        bm1    = hamming2(sym, exp_sym(P1, NS[1]));
        cand0  = pm_p0 + {{(METRIC_W-2){1'b0}}, bm0};
        cand1  = pm_p1 + {{(METRIC_W-2){1'b0}}, bm1};
        dec    = 1'b0;
        new_pm = cand0;
        if (cand1 < cand0) begin
            dec    = 1'b1;
            new_pm = cand1;
        end
    end

endmodule

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder, 4 states, register-exchange survivors of DEPTH symbols.
module viterbi_decoder_k3
    import viterbi_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int METRIC_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] sym_i,
    output logic       d_out,
    output logic       valid_o
);

    localparam int CNT_W = $clog2(DEPTH);

    logic [METRIC_W-1:0] pm       [NUM_STATES];
    logic [METRIC_W-1:0] raw_pm   [NUM_STATES];
    logic [METRIC_W-1:0] norm_pm  [NUM_STATES];
    logic [DEPTH-1:0]    path     [NUM_STATES];
    logic [DEPTH-1:0]    new_path [NUM_STATES];
    logic [NUM_STATES-1:0] dec;
    logic [METRIC_W-1:0] min_pm;
    state_t              best;
    state_t              st;
    state_t              pred;
    logic [CNT_W-1:0]    count;

    genvar g;
    generate
        for (g = 0; g < NUM_STATES; g++) begin : g_acs
            localparam state_t NSV = state_t'(g);
            viterbi_acs #(
                .METRIC_W (METRIC_W),
                .NS       (NSV)
            ) u_acs (
                .pm_p0  (pm[{NSV[0], 1'b0}]),
                .pm_p1  (pm[{NSV[0], 1'b1}]),
                .sym    (sym_i),
                .new_pm (raw_pm[g]),
                .dec    (dec[g])
            );
        end
    endgenerate

    // Minimum metric, best state (lowest index on ties), normalised metrics and survivor exchange.
    always_comb begin
        min_pm = raw_pm[0];
        best   = 2'b00;
        st     = 2'b00;
        pred   = 2'b00;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (raw_pm[i] < min_pm) begin
                min_pm = raw_pm[i];
            end
        end
        for (int i = NUM_STATES - 1; i >= 0; i--) begin
            if (raw_pm[i] == min_pm) begin
                best = state_t'(i);
            end
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            st          = state_t'(i);
            pred        = {st[0], dec[i]};
            norm_pm[i]  = raw_pm[i] - min_pm;
            new_path[i] = {path[pred][DEPTH-2:0], st[1]};
        end
    end

    // Metric, survivor and symbol-count state advances only on accepted symbols.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= (i == 0) ? '0 : METRIC_W'(INIT_PEN);
                path[i] <= '0;
            end
            count <= '0;
        end else if (en_i) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= norm_pm[i];
                path[i] <= new_path[i];
            end
            if (count != CNT_W'(DEPTH - 1)) begin
                count <= count + 1'b1;
            end
        end
    end

    // Oldest bit of the best survivor, flagged valid once DEPTH symbols have arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out   <= 1'b0;
            valid_o <= 1'b0;
        end else if (en_i) begin
            d_out   <= new_path[best][DEPTH-1];
            valid_o <= (count == CNT_W'(DEPTH - 1));
        end else begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Self-checking bench: random streams through a trellis/traceback reference model.
module tb_viterbi_decoder_k3;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en_i = 1'b0;
   logic [1:0] sym_i = 2'b00;
   logic       d_out;
   logic       valid_o;

   int errors = 0;
   int checks = 0;

   // Encoder history bits.
   bit enc_a;
   bit enc_b;

   // Reference model: full metrics and decision history, decoded by traceback.
   int         m_pm [4];
   logic [3:0] m_dec [$];
   int         m_n;

   bit src [256];

   viterbi_decoder_k3 #(
      .DEPTH    (DEPTH),
      .METRIC_W (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en_i),
      .sym_i   (sym_i),
      .d_out   (d_out),
      .valid_o (valid_o)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic model_reset();
      m_pm[0] = 0;
      m_pm[1] = 4;
      m_pm[2] = 4;
      m_pm[3] = 4;
      m_dec.delete();
      m_n   = 0;
      enc_a = 1'b0;
      enc_b = 1'b0;
   endtask

   task automatic enc_bit(input bit u, input bit flip0, output logic [1:0] s);
      s     = {u ^ enc_a ^ enc_b, u ^ enc_b ^ flip0};
      enc_b = enc_a;
      enc_a = u;
   endtask

   task automatic model_step(input logic [1:0] sym, output bit ev, output bit eb);
      int         np [4];
      logic [3:0] d;
      int         best;
      int         s;
      d = 4'b0000;
      for (int ns = 0; ns < 4; ns++) begin
         int u;
         int a;
         int c [2];
         u = ns / 2;
         a = ns % 2;
         for (int pick = 0; pick < 2; pick++) begin
            logic [1:0] e;
            e = 2'(((u ^ a ^ pick) & 1) * 2 + ((u ^ pick) & 1));
            c[pick] = m_pm[2 * a + pick] + $countones(sym ^ e);
         end
         if (c[1] < c[0]) begin
            np[ns] = c[1];
            d[ns]  = 1'b1;
         end else begin
            np[ns] = c[0];
         end
      end
      best = 0;
      for (int i = 1; i < 4; i++) begin
         if (np[i] < np[best]) best = i;
      end
      m_pm = np;
      m_dec.push_back(d);
      ev = (m_n >= DEPTH - 1);
      eb = 1'b0;
      if (ev) begin
         s = best;
         for (int k = m_n; k > m_n - DEPTH + 1; k--) begin
            s = (s % 2) * 2 + int'(m_dec[k][s]);
         end
         eb = bit'(s / 2);
      end
      m_n++;
   endtask

   task automatic cycle(input logic en, input logic [1:0] sym);
      en_i  = en;
      sym_i = sym;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cycle(1'b0, 2'b00);
      cycle(1'b0, 2'b00);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) src[i] = bit'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      logic [1:0] s;
      bit ev, eb;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 2'(i + 1));
         checks++;
         if (valid_o !== 1'b0 || d_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold cyc=%0d valid=%b d=%b want 0/0", i, valid_o, d_out);
         end
      end
      rst = 1'b1;
      model_reset();
      fill_random();
      for (int i = 0; i < DEPTH; i++) begin
         enc_bit(src[i], 1'b0, s);
         model_step(s, ev, eb);
         cycle(1'b1, s);
         checks++;
         if (valid_o !== (i == DEPTH - 1)) begin
            errors++;
            $display("[TB] FAIL reset_first_valid sym=%0d valid=%b want %b", i, valid_o, i == DEPTH - 1);
         end
      end
      checks++;
      if (d_out !== src[0]) begin
         errors++;
         $display("[TB] FAIL reset_first_bit d=%b want %b", d_out, src[0]);
      end
   endtask

   task automatic test_clean();
      logic [1:0] s;
      bit ev, eb;
      int nvalid;
      nvalid = 0;
      do_reset();
      for (int i = 0; i < 32; i++) src[i] = (i < 4) ? bit'(4'b1101 >> i) : 1'b0;
      for (int i = 0; i < 32; i++) begin
         enc_bit(src[i], 1'b0, s);
         model_step(s, ev, eb);
         cycle(1'b1, s);
         checks++;
         if (valid_o !== ev) begin
            errors++;
            $display("[TB] FAIL clean_valid sym=%0d valid=%b want %b", i, valid_o, ev);
         end
         if (valid_o === 1'b1) nvalid++;
         if (ev) begin
            checks++;
            if (d_out !== src[i - DEPTH + 1]) begin
               errors++;
               $display("[TB] FAIL clean_bit sym=%0d d=%b want %b", i, d_out, src[i - DEPTH + 1]);
            end
         end
      end
      checks++;
      if (nvalid != 17) begin
         errors++;
         $display("[TB] FAIL clean_valid_count got=%0d want 17", nvalid);
      end
   endtask

   task automatic test_errors(input bit burst);
      logic [1:0] s;
      bit ev, eb, flip;
      do_reset();
      fill_random();
      for (int i = 0; i < 256; i++) begin
         flip = (i % 16 == 14) || (burst && (i % 16 == 15));
         enc_bit(src[i], flip, s);
         model_step(s, ev, eb);
         cycle(1'b1, s);
         checks++;
         if (valid_o !== ev) begin
            errors++;
            $display("[TB] FAIL err_valid burst=%0d sym=%0d valid=%b want %b", burst, i, valid_o, ev);
         end
         if (ev) begin
            checks++;
            if (d_out !== eb) begin
               errors++;
               $display("[TB] FAIL err_model burst=%0d sym=%0d d=%b want %b", burst, i, d_out, eb);
            end
            checks++;
            if (d_out !== src[i - DEPTH + 1]) begin
               errors++;
               $display("[TB] FAIL err_source burst=%0d sym=%0d d=%b want %b", burst, i, d_out, src[i - DEPTH + 1]);
            end
         end
      end
   endtask

   task automatic test_enable_gaps();
      logic [1:0] s;
      bit ev, eb, en;
      bit pat [6] = '{1, 0, 0, 1, 1, 0};
      int acc, c, ndec;
      logic prev_d;
      do_reset();
      fill_random();
      acc = 0;
      c = 0;
      ndec = 0;
      prev_d = d_out;
      while (acc < 64) begin
         en = pat[c % 6];
         ev = 1'b0;
         s  = 2'(c);
         if (en) begin
            enc_bit(src[acc], 1'b0, s);
            model_step(s, ev, eb);
         end
         cycle(en, s);
         checks++;
         if (valid_o !== ev) begin
            errors++;
            $display("[TB] FAIL gap_valid cyc=%0d en=%b valid=%b want %b", c, en, valid_o, ev);
         end
         if (en && ev) begin
            ndec++;
            checks++;
            if (d_out !== src[acc - DEPTH + 1]) begin
               errors++;
               $display("[TB] FAIL gap_bit sym=%0d d=%b want %b", acc, d_out, src[acc - DEPTH + 1]);
            end
         end else if (!en) begin
            checks++;
            if (d_out !== prev_d) begin
               errors++;
               $display("[TB] FAIL gap_hold cyc=%0d d=%b want %b", c, d_out, prev_d);
            end
         end
         if (en) acc++;
         prev_d = d_out;
         c++;
      end
      checks++;
      if (ndec != 64 - DEPTH + 1) begin
         errors++;
         $display("[TB] FAIL gap_count got=%0d want %0d", ndec, 64 - DEPTH + 1);
      end
   endtask

   task automatic test_reset_midstream();
      logic [1:0] s;
      bit ev, eb;
      do_reset();
      fill_random();
      for (int i = 0; i < 20; i++) begin
         enc_bit(src[i], 1'b0, s);
         model_step(s, ev, eb);
         cycle(1'b1, s);
      end
      checks++;
      if (valid_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_pre_valid valid=%b want 1", valid_o);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (valid_o !== 1'b0 || d_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_async valid=%b d=%b want 0/0", valid_o, d_out);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 24; i++) src[i] = bit'($urandom_range(0, 1));
      for (int i = 0; i < 24; i++) begin
         enc_bit(src[i], 1'b0, s);
         model_step(s, ev, eb);
         cycle(1'b1, s);
         checks++;
         if (valid_o !== (i >= DEPTH - 1)) begin
            errors++;
            $display("[TB] FAIL mid_valid sym=%0d valid=%b want %b", i, valid_o, i >= DEPTH - 1);
         end
         if (i >= DEPTH - 1) begin
            checks++;
            if (d_out !== src[i - DEPTH + 1]) begin
               errors++;
               $display("[TB] FAIL mid_bit sym=%0d d=%b want %b", i, d_out, src[i - DEPTH + 1]);
            end
         end
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      $display("[TB] start");
      test_reset();
      test_clean();
      test_errors(1'b0);
      test_errors(1'b1);
      test_enable_gaps();
      test_reset_midstream();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      if (errors == 0)
         $display("[TB] PASS");
      else
         $display("[TB] FAIL");
      $finish;
   end

endmodule

// File: doc/viterbi_decoder_k3.md
Name: viterbi_decoder_k3

Overview:
Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7,5 octal) produced by the team's encoder. It sits on the receive side of the channel: it accepts one 2-bit symbol per enabled clock and emits one decoded bit per enabled clock after a fixed latency. It uses 4-state add-compare-select with metric normalisation and register-exchange survivor paths.

Parameters:
- DEPTH, 16, survivor path length in symbols (decoding latency); legal range 4..64.
- METRIC_W, 4, path-metric width in bits; minimum 4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en_i  input  1  symbol valid; symbol accepted on a rising clk edge when en_i=1.
- sym_i  input  2  received symbol {o1,o0}.
- d_out  output  1  decoded bit, registered.
- valid_o  output  1  d_out valid, registered; one pulse per accepted symbol once primed.

Behaviour:
- Code definition:
  - State s={a,b}, with a = previous input bit and b = the bit before it.
  - For input u: o1=u^a^b, o0=u^b; next state={u,a}.
  - Encoder starts in state 00.
- Branch metric: Hamming distance between sym_i and the expected {o1,o0}, range 0..2.
- ACS for next state ns={u,a}:
  - Predecessors are p0={a,0} and p1={a,1}.
  - cand_k = pm[p_k] + bm(p_k,u).
  - Select the smaller candidate; on a tie select p0.
- Normalisation: after ACS, subtract the minimum of the 4 new metrics from all 4 metrics, so min is always 0. Metrics never overflow at METRIC_W>=4; no saturation logic.
- Path update: path[ns] <= {path[sel_pred][DEPTH-2:0], u}. The MSB is the oldest bit.
- Best state: the state with the lowest new metric; on a tie, the lowest state index.
- Output on each accepting edge for symbol n (0-based since reset):
  - d_out <= new_path[best][DEPTH-1].
  - valid_o <= (n >= DEPTH-1).
  - Bit k of the transmitted stream appears with the edge that accepts symbol k+DEPTH-1.
- When en_i=0:
  - pm, path and count hold.
  - valid_o <= 0; d_out holds.
- Symbol counter: saturates at DEPTH-1; it never wraps.
- Reset (asynchronous, any time, including mid-stream):
  - pm[0]=0, pm[1..3]=4 (INIT_PEN).
  - All paths=0, count=0.
  - d_out=0, valid_o=0.
  - The first symbol after reset release is treated as n=0.
- Error correction: every pattern of at most 2 bit errors within any window of 5 consecutive symbols is corrected, given DEPTH>=16 and otherwise clean input.

Decomposition:
- Shared package viterbi_pkg containing:
  - NUM_STATES=4 and INIT_PEN=4.
  - typedef state_t (logic [1:0]).
  - Function exp_sym(state_t s, logic u) returning {o1,o0}.
  - Function hamming2 for the branch metric.
- One sub-module viterbi_acs (a single next state: two candidates, compare, tie rule, decision bit), instantiated 4x.
- Minimum finding, normalisation, path registers and output logic stay in viterbi_decoder_k3.

Test Plan:
- Reset check: hold rst=0 for 3 clocks with en_i=1 toggling sym_i -> d_out=0, valid_o=0 throughout; first valid_o=1 on the 16th accepted symbol after release (DEPTH=16).
- Clean stream: bits 1,0,1,1 followed by 28 zeros encode to 11,10,00,01,01,11,00,... -> decoded bits 1,0,1,1,0,... with valid_o pulses starting on symbol 15; exactly 17 valid outputs for 32 symbols.
- Isolated errors: random 256-bit stream, bit0 of every symbol with index%16==14 inverted -> decoded stream equals source, 0 bit errors.
- Two-error burst: same stream, bit0 inverted on symbols with index%16==14 and 15 -> 0 decoded errors.
- Enable gaps: en_i pattern 1,0,0,1,1,0 repeated over a 64-bit clean stream -> decoded sequence identical to the gap-free run; valid_o never high in a cycle following en_i=0; pm/path unchanged across idle cycles.
- Reset mid-stream: assert rst after 20 accepted symbols, restart encoder from state 00 -> valid_o drops immediately; next valid_o on the 16th symbol after release; output matches the new stream.
